l1_d_ctrl_nway: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate L1 data-cache controller: tag/valid/dirty arrays, hit/miss detection, victim selection, L2 write-back/refill handshakes and a full dirty-line flush walk. Sits between the core's load/store port and the L2 request port and drives the L1 data array through `refill`, `update` and `way_o`. It supersedes the fixed 2-way controller with configurable ways, sets and tag width, write-back of dirty victims on read misses too, and a flush that writes dirty lines back instead of discarding them.

---
 rtl/l1_d_ctrl_nway.sv | 244 ++++++++++++++++++++++++
 tb/tb_l1_d_ctrl_nway.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_d_ctrl_nway.sv
// N-way set-associative write-back / write-allocate L1 data-cache controller.
// Holds tag/valid/dirty state, picks victims and sequences L2 write-back, refill and flush.
module l1_d_ctrl_nway #(
   parameter  int TAG_W = 21,
   parameter  int IDX_W = 5,
   parameter  int WAYS  = 4,
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [TAG_W-1:0]       tag_i,
   input  logic [IDX_W-1:0]       index_i,
   input  logic                   read_i,
   input  logic                   write_i,
   input  logic                   flush_i,
   input  logic                   ready_L2_L1,
   output logic                   stall,
   output logic                   hit_o,
   output logic                   miss_o,
   output logic                   update,
   output logic                   refill,
   output logic [WAY_W-1:0]       way_o,
   output logic                   read_L1_L2,
   output logic                   write_L1_L2,
   output logic [TAG_W+IDX_W-1:0] addr_L1_L2,
   output logic [TAG_W+IDX_W-1:0] wb_addr_L1_L2,
   output logic                   flush_done
);

   localparam int SETS = 1 << IDX_W;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITE_BACK,
      ALLOCATE,
      FLUSH_SCAN,
      FLUSH_WB
   } state_t;

   state_t state, state_nxt;

   logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
   logic [WAYS-1:0]  valid_mem [SETS];
   logic [WAYS-1:0]  dirty_mem [SETS];
   logic [WAY_W-1:0] rr_ptr    [SETS];

   logic [IDX_W-1:0] scan_set;
   logic [WAY_W-1:0] scan_way;
   logic [WAY_W-1:0] victim;
   logic             victim_repl;

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             has_inv;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] victim_sel;
   logic             victim_dirty;
   logic             scan_dirty;
   logic             scan_last;

   // Tag match and victim choice: lowest invalid way first, otherwise the set's round-robin pointer.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_mem[index_i][w] && (tag_mem[index_i][w] == tag_i)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_mem[index_i][w]) begin
            has_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      if (has_inv)
         victim_sel = inv_way;
      else if (WAYS == 1)
         victim_sel = '0;
      else
         victim_sel = rr_ptr[index_i];
      victim_dirty = valid_mem[index_i][victim_sel] && dirty_mem[index_i][victim_sel];
      scan_dirty   = valid_mem[scan_set][scan_way] && dirty_mem[scan_set][scan_way];
      scan_last    = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and output decode; every output is a pure function of state and current lookup.
   always_comb begin
      state_nxt     = state;
      hit_o         = 1'b0;
      miss_o        = 1'b0;
      update        = 1'b0;
      refill        = 1'b0;
      way_o         = '0;
      read_L1_L2    = 1'b0;
      write_L1_L2   = 1'b0;
      wb_addr_L1_L2 = '0;
      flush_done    = 1'b0;
      case (state)
         IDLE: begin
            if (flush_i)
               state_nxt = FLUSH_SCAN;
            else if (read_i || write_i)
               state_nxt = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               hit_o     = 1'b1;
               way_o     = hit_way;
               update    = write_i;
               state_nxt = IDLE;
            end else begin
               miss_o    = 1'b1;
               way_o     = victim_sel;
               state_nxt = victim_dirty ? WRITE_BACK : ALLOCATE;
            end
         end
         WRITE_BACK: begin
            write_L1_L2   = 1'b1;
            way_o         = victim;
            wb_addr_L1_L2 = {tag_mem[index_i][victim], index_i};
            if (ready_L2_L1)
               state_nxt = ALLOCATE;
         end
         ALLOCATE: begin
            read_L1_L2 = 1'b1;
            way_o      = victim;
            if (ready_L2_L1) begin
               refill    = 1'b1;
               state_nxt = COMPARE;
            end
         end
         FLUSH_SCAN: begin
            if (scan_dirty)
               state_nxt = FLUSH_WB;
            else if (scan_last) begin
               flush_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         FLUSH_WB: begin
            write_L1_L2   = 1'b1;
            way_o         = scan_way;
            wb_addr_L1_L2 = {tag_mem[scan_set][scan_way], scan_set};
            if (ready_L2_L1) begin
               if (scan_last) begin
                  flush_done = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt = FLUSH_SCAN;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Cache metadata, victim latch and flush scan counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            rr_ptr[s]    <= '0;
            for (int w = 0; w < WAYS; w++)
               tag_mem[s][w] <= '0;
         end
         scan_set    <= '0;
         scan_way    <= '0;
         victim      <= '0;
         victim_repl <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (flush_i) begin
                  scan_set <= '0;
                  scan_way <= '0;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (write_i)
                     dirty_mem[index_i][hit_way] <= 1'b1;
               end else begin
                  victim      <= victim_sel;
                  victim_repl <= !has_inv;
               end
            end
            WRITE_BACK: begin
               if (ready_L2_L1)
                  dirty_mem[index_i][victim] <= 1'b0;
            end
            ALLOCATE: begin
               if (ready_L2_L1) begin
                  tag_mem[index_i][victim]   <= tag_i;
                  valid_mem[index_i][victim] <= 1'b1;
                  dirty_mem[index_i][victim] <= 1'b0;
                  if (victim_repl && (WAYS > 1))
                     rr_ptr[index_i] <= rr_ptr[index_i] + 1'b1;
               end
            end
            FLUSH_SCAN: begin
               if (!scan_dirty) begin
                  valid_mem[scan_set][scan_way] <= 1'b0;
                  if (scan_way == WAY_W'(WAYS - 1)) begin
                     scan_way <= '0;
                     scan_set <= scan_set + 1'b1;
                  end else begin
                     scan_way <= scan_way + 1'b1;
                  end
               end
            end
            FLUSH_WB: begin
               if (ready_L2_L1) begin
                  valid_mem[scan_set][scan_way] <= 1'b0;
                  dirty_mem[scan_set][scan_way] <= 1'b0;
                  if (scan_way == WAY_W'(WAYS - 1)) begin
                     scan_way <= '0;
                     scan_set <= scan_set + 1'b1;
                  end else begin
                     scan_way <= scan_way + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign stall      = (state != IDLE);
   assign addr_L1_L2 = {tag_i, index_i};

endmodule

// File: tb/tb_l1_d_ctrl_nway.sv
// Scoreboard bench for l1_d_ctrl_nway: directed accesses push expected events,
// a negedge monitor pops and compares whatever the controller presents.
module tb_l1_d_ctrl_nway;

   localparam int TAG_W = 21;
   localparam int IDX_W = 5;
   localparam int WAYS  = 4;
   localparam int WAY_W = 2;

   localparam int K_HIT    = 0;
   localparam int K_MISS   = 1;
   localparam int K_REFILL = 2;
   localparam int K_WB     = 3;
   localparam int K_DONE   = 4;
   localparam int K_END    = 5;

   typedef struct {
      int kind;
      int way;
      int addr;
      int upd;
      int len;
   } ev_t;

   logic                   clk = 1'b0;
   logic                   nrst = 1'b0;
   logic [TAG_W-1:0]       tag_i = '0;
   logic [IDX_W-1:0]       index_i = '0;
   logic                   read_i = 1'b0;
   logic                   write_i = 1'b0;
   logic                   flush_i = 1'b0;
   logic                   ready_L2_L1 = 1'b0;
   logic                   stall;
   logic                   hit_o;
   logic                   miss_o;
   logic                   update;
   logic                   refill;
   logic [WAY_W-1:0]       way_o;
   logic                   read_L1_L2;
   logic                   write_L1_L2;
   logic [TAG_W+IDX_W-1:0] addr_L1_L2;
   logic [TAG_W+IDX_W-1:0] wb_addr_L1_L2;
   logic                   flush_done;

   ev_t exp_q[$];
   int  compared   = 0;
   int  mismatched = 0;
   int  ev_num     = 0;
   int  l2_delay   = 0;
   int  l2_cnt     = 0;
   int  stall_len  = 0;

   l1_d_ctrl_nway #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .tag_i         (tag_i),
      .index_i       (index_i),
      .read_i        (read_i),
      .write_i       (write_i),
      .flush_i       (flush_i),
      .ready_L2_L1   (ready_L2_L1),
      .stall         (stall),
      .hit_o         (hit_o),
      .miss_o        (miss_o),
      .update        (update),
      .refill        (refill),
      .way_o         (way_o),
      .read_L1_L2    (read_L1_L2),
      .write_L1_L2   (write_L1_L2),
      .addr_L1_L2    (addr_L1_L2),
      .wb_addr_L1_L2 (wb_addr_L1_L2),
      .flush_done    (flush_done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic int lineAddr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
      logic [TAG_W+IDX_W-1:0] a;
      a = {t, i};
      return int'(a);
   endfunction

   function automatic void pushEv(input int kind, input int way, input int addr, input int upd, input int len);
      ev_t e;
      e.kind = kind;
      e.way  = way;
      e.addr = addr;
      e.upd  = upd;
      e.len  = len;
      exp_q.push_back(e);
   endfunction

   function automatic void pushHit(input int way, input int upd);
      pushEv(K_HIT, way, 0, upd, 0);
      pushEv(K_END, 0, 0, 0, 1);
   endfunction

   function automatic void pushCleanMiss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                         input int way, input int upd, input int k);
      pushEv(K_MISS, 0, lineAddr(t, i), 0, 0);
      pushEv(K_REFILL, way, lineAddr(t, i), 0, 0);
      pushEv(K_HIT, way, 0, upd, 0);
      pushEv(K_END, 0, 0, 0, k + 3);
   endfunction

   function automatic void pushDirtyMiss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                         input int way, input logic [TAG_W-1:0] wb_tag,
                                         input int upd, input int k);
      pushEv(K_MISS, 0, lineAddr(t, i), 0, 0);
      pushEv(K_WB, way, lineAddr(wb_tag, i), 0, 0);
      pushEv(K_REFILL, way, lineAddr(t, i), 0, 0);
      pushEv(K_HIT, way, 0, upd, 0);
      pushEv(K_END, 0, 0, 0, 2 * k + 4);
   endfunction

   task automatic checkEvent(input int kind, input int way, input int addr, input int upd, input int len);
      ev_t e;
      ev_num++;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL unexpected_ev%0d: got kind %0d, required no event", ev_num, kind);
      end else begin
         e = exp_q.pop_front();
         checkOutput($sformatf("ev%0d.kind", ev_num), kind, e.kind);
         checkOutput($sformatf("ev%0d.update", ev_num), upd, e.upd);
         if (kind == e.kind) begin
            if (kind == K_HIT || kind == K_REFILL || kind == K_WB)
               checkOutput($sformatf("ev%0d.way", ev_num), way, e.way);
            if (kind == K_MISS || kind == K_REFILL || kind == K_WB)
               checkOutput($sformatf("ev%0d.addr", ev_num), addr, e.addr);
            if (kind == K_END)
               checkOutput($sformatf("ev%0d.stall_len", ev_num), len, e.len);
         end
      end
   endtask

   // L2 model: raises ready l2_delay cycles after a request appears, for one cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!nrst) begin
            ready_L2_L1 = 1'b0;
            l2_cnt      = 0;
         end else begin
            if (ready_L2_L1) begin
               ready_L2_L1 = 1'b0;
               l2_cnt      = 0;
            end
            if (read_L1_L2 || write_L1_L2) begin
               if (l2_cnt >= l2_delay)
                  ready_L2_L1 = 1'b1;
               else
                  l2_cnt++;
            end
         end
      end
   end

   // Monitor: every visible controller event is compared against the scoreboard queue.
   always @(negedge clk) begin
      if (!nrst) begin
         stall_len = 0;
      end else begin
         if (read_L1_L2 && write_L1_L2)
            checkOutput("l2_req_exclusive", 1, 0);
         if (hit_o)
            checkEvent(K_HIT, int'(way_o), 0, int'(update), 0);
         if (miss_o)
            checkEvent(K_MISS, 0, int'(addr_L1_L2), int'(update), 0);
         if (refill)
            checkEvent(K_REFILL, int'(way_o), int'(addr_L1_L2), int'(update), 0);
         if (write_L1_L2 && ready_L2_L1)
            checkEvent(K_WB, int'(way_o), int'(wb_addr_L1_L2), int'(update), 0);
         if (flush_done)
            checkEvent(K_DONE, 0, 0, int'(update), 0);
         if (stall) begin
            stall_len++;
         end else if (stall_len > 0) begin
            checkEvent(K_END, 0, 0, int'(update), stall_len);
            stall_len = 0;
         end
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic fl,
                                input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i, input int k);
      int cycles;
      cycles   = 0;
      l2_delay = k;
      @(posedge clk);
      #1;
      tag_i   = t;
      index_i = i;
      read_i  = rd;
      write_i = wr;
      flush_i = fl;
      while (1) begin
         @(posedge clk);
         #1;
         flush_i = 1'b0;
         cycles++;
         if (!stall || cycles >= 400)
            break;
      end
      read_i  = 1'b0;
      write_i = 1'b0;
      if (stall)
         checkOutput("stimulus_timeout", 1, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      tag_i   = 21'h00015;
      index_i = 5'd2;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.stall", int'(stall), 0);
      checkOutput("rst.hit", int'(hit_o), 0);
      checkOutput("rst.miss", int'(miss_o), 0);
      checkOutput("rst.refill", int'(refill), 0);
      checkOutput("rst.read_l2", int'(read_L1_L2), 0);
      checkOutput("rst.write_l2", int'(write_L1_L2), 0);
      checkOutput("rst.flush_done", int'(flush_done), 0);
      checkOutput("rst.wb_addr", int'(wb_addr_L1_L2), 0);
      checkOutput("rst.addr_follows", int'(addr_L1_L2), lineAddr(21'h00015, 5'd2));
      nrst = 1'b1;

      // first read misses into way 0, refill after two wait cycles
      pushCleanMiss(21'h1A2B3, 5'd3, 0, 0, 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h1A2B3, 5'd3, 2);
      pushHit(0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h1A2B3, 5'd3, 0);
      pushHit(0, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 21'h1A2B3, 5'd3, 0);

      // fill the remaining ways of set 3 (invalid ways chosen lowest first)
      for (int w = 1; w < WAYS; w++) begin
         pushCleanMiss(TAG_W'(w), 5'd3, w, 0, 0);
         applyStimulus(1'b1, 1'b0, 1'b0, TAG_W'(w), 5'd3, 0);
      end

      // set full: write miss evicts dirty way 0 via rr_ptr, rr_ptr -> 1
      pushDirtyMiss(21'h0ABCD, 5'd3, 0, 21'h1A2B3, 1, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 21'h0ABCD, 5'd3, 1);

      // dirty way 1 then read miss: write-back before refill, no update
      pushHit(1, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 21'h00001, 5'd3, 0);
      pushDirtyMiss(21'h0DDDD, 5'd3, 1, 21'h00001, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h0DDDD, 5'd3, 0);
      pushCleanMiss(21'h0EEEE, 5'd3, 2, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h0EEEE, 5'd3, 0);

      // dirty lines at set 0 way 1 and set 31 way 3
      pushCleanMiss(21'h00010, 5'd0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h00010, 5'd0, 0);
      pushCleanMiss(21'h00011, 5'd0, 1, 1, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 21'h00011, 5'd0, 0);
      for (int w = 0; w < WAYS - 1; w++) begin
         pushCleanMiss(TAG_W'(32'h100 + w), 5'd31, w, 0, 0);
         applyStimulus(1'b1, 1'b0, 1'b0, TAG_W'(32'h100 + w), 5'd31, 0);
      end
      pushCleanMiss(21'h00103, 5'd31, 3, 1, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 21'h00103, 5'd31, 0);

      // flush: write-backs in {set, way} order, done on the last one
      pushEv(K_WB, 1, lineAddr(21'h00011, 5'd0), 0, 0);
      pushEv(K_WB, 0, lineAddr(21'h0ABCD, 5'd3), 0, 0);
      pushEv(K_WB, 3, lineAddr(21'h00103, 5'd31), 0, 0);
      pushEv(K_DONE, 0, 0, 0, 0);
      pushEv(K_END, 0, 0, 0, 32 * WAYS + 3 * 2);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 1);

      pushCleanMiss(21'h1A2B3, 5'd3, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h1A2B3, 5'd3, 0);

      // clean flush takes exactly SETS*WAYS cycles
      pushEv(K_DONE, 0, 0, 0, 0);
      pushEv(K_END, 0, 0, 0, 32 * WAYS);
      applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 0);

      // reset during ALLOCATE aborts the refill
      l2_delay = 20;
      pushEv(K_MISS, 0, lineAddr(21'h0F0F0, 5'd5), 0, 0);
      @(posedge clk);
      #1;
      tag_i   = 21'h0F0F0;
      index_i = 5'd5;
      read_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("alloc.read_l2", int'(read_L1_L2), 1);
      #1;
      nrst = 1'b0;
      #1;
      checkOutput("abort.stall", int'(stall), 0);
      checkOutput("abort.read_l2", int'(read_L1_L2), 0);
      checkOutput("abort.way", int'(way_o), 0);
      read_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      pushCleanMiss(21'h0F0F0, 5'd5, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 21'h0F0F0, 5'd5, 0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
